imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pkg.sv | 33 +++
 rtl/imm_gen_decode.sv | 84 ++++++++
 rtl/imm_gen_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared format codes, opcode constants and target-select helper for imm_gen_pipe
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6,
    FMT_X = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;

  // Branches, jumps and AUIPC produce pc+imm; everything else produces pc+4.
  function automatic logic uses_pc_target(input fmt_e f, input logic [6:0] opcode);
    return (f == FMT_B) || (f == FMT_J) || ((f == FMT_U) && (opcode == OP_AUIPC));
  endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// rtl/imm_gen_decode.sv - combinational format/immediate decode; IMM_GEN_PIPE_ZIMM_EN enables CSR zimm format
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // U immediate: bit 31 is inst[31], so filling every upper bit with inst[31] gives the sign extension on RV64.
  always_comb begin
    imm_u        = {{(XLEN-12){inst[31]}}, 12'h000};
    imm_u[30:12] = inst[30:12];
  end

  // Opcode to format and immediate selection; unknown opcodes fall through to the illegal format.
  always_comb begin
    fmt = FMT_X;
    imm = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = imm_i;
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_PIPE_ZIMM_EN
        if (inst[14]) begin
          fmt = FMT_Z;
          imm = {{(XLEN-5){1'b0}}, inst[19:15]};
        end else begin
          fmt = FMT_I;
          imm = imm_i;
        end
`else
        fmt = FMT_I;
        imm = imm_i;
`endif
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt = FMT_I;
          imm = imm_i;
        end
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = imm_s;
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = imm_u;
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = imm_j;
      end
      OP_OP: fmt = FMT_R;
      OP_OP_32: begin
        if (XLEN == 64) fmt = FMT_R;
      end
      default: fmt = FMT_X;
    endcase
    illegal = (fmt == FMT_X);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with skid buffer; IMM_GEN_PIPE_ZIMM_EN selects zimm decode
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic [XLEN-1:0]  target,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic [XLEN-1:0] new_target;

  logic            out_valid_q;
  logic [XLEN-1:0] out_imm_q;
  fmt_e            out_fmt_q;
  logic [XLEN-1:0] out_target_q;
  logic            out_illegal_q;

  logic            skid_valid_q;
  logic [XLEN-1:0] skid_imm_q;
  fmt_e            skid_fmt_q;
  logic [XLEN-1:0] skid_target_q;
  logic            skid_illegal_q;

  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic consume;
  logic out_free;

  imm_gen_decode #(.XLEN(XLEN)) u_decode (
    .inst    (inst),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign new_target = pc + (uses_pc_target(dec_fmt, inst[6:0]) ? dec_imm : PC_STEP);

  // Ready depends only on skid occupancy, so there is no combinational path from out_ready.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;
  assign out_free = consume || !out_valid_q;

  // Output register refills from skid first (ordering), else from the decoder; a held output diverts input to skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_R;
      out_target_q   <= '0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_R;
      skid_target_q  <= '0;
      skid_illegal_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q   <= 1'b1;
        out_imm_q     <= skid_imm_q;
        out_fmt_q     <= skid_fmt_q;
        out_target_q  <= skid_target_q;
        out_illegal_q <= skid_illegal_q;
        skid_valid_q  <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) begin
          out_imm_q     <= dec_imm;
          out_fmt_q     <= dec_fmt;
          out_target_q  <= new_target;
          out_illegal_q <= dec_illegal;
        end
      end
    end else if (accept) begin
      skid_valid_q   <= 1'b1;
      skid_imm_q     <= dec_imm;
      skid_fmt_q     <= dec_fmt;
      skid_target_q  <= new_target;
      skid_illegal_q <= dec_illegal;
    end
  end

  // Count illegal bundles as they leave, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (consume && out_illegal_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = out_valid_q;
  assign imm         = out_imm_q;
  assign fmt         = out_fmt_q;
  assign target      = out_target_q;
  assign illegal     = out_illegal_q;
  assign illegal_cnt = cnt_q;

endmodule
